// File: rtl/csr_pkg.sv
// Shared definitions for the LoongArch32 CSR file: CSR indices, exception codes,
// field bit positions, writable-bit masks and the masked-write helper.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam int unsigned CRMD_PLV_LO    = 32'd0;
    localparam int unsigned CRMD_IE        = 32'd2;
    localparam int unsigned CRMD_DA        = 32'd3;
    localparam int unsigned PRMD_PPLV_LO   = 32'd0;
    localparam int unsigned PRMD_PIE       = 32'd2;
    localparam int unsigned ESTAT_IS_HW_LO = 32'd2;
    localparam int unsigned ESTAT_IS_RSV   = 32'd10;
    localparam int unsigned ESTAT_IS_TI    = 32'd11;
    localparam int unsigned ESTAT_IS_IPI   = 32'd12;
    localparam int unsigned ESTAT_ECODE_LO = 32'd16;
    localparam int unsigned ESTAT_ESUB_LO  = 32'd22;
    localparam int unsigned TCFG_EN        = 32'd0;
    localparam int unsigned TCFG_PERIODIC  = 32'd1;
    localparam int unsigned TCFG_INITV_LO  = 32'd2;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] CRMD_RST     = 32'h0000_0008;

    // Which single event owns the register file this cycle.
    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_WRITE = 2'd1,
        EVT_ERTN  = 2'd2,
        EVT_EX    = 2'd3
    } csr_evt_e;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                              input logic [31:0] mask_v,
                                              input logic [31:0] new_v);
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: TID/TCFG/TVAL state, the enable flag and the one-cycle fire
// pulse that sets ESTAT.IS[11] in the parent.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [13:0] num_i,
    input  logic [31:0] wmask_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] tid_o,
    output logic [31:0] tcfg_o,
    output logic [31:0] tval_o,
    output logic        fire_o
);

    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic        en_q, en_d;
    logic        fire_s;

    // Next-state: a TCFG write restarts the count and overrides this cycle's tick.
    always_comb begin
        tid_d  = tid_q;
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        en_d   = en_q;
        fire_s = 1'b0;
        if (we_i && (num_i == CSR_TID)) begin
            tid_d = csr_merge(tid_q, wmask_i, wvalue_i);
        end else begin
            tid_d = tid_q;
        end
        if (we_i && (num_i == CSR_TCFG)) begin
            tcfg_d = csr_merge(tcfg_q, wmask_i, wvalue_i);
            tval_d = {tcfg_d[31:TCFG_INITV_LO], 2'b00};
            en_d   = tcfg_d[TCFG_EN];
        end else if (en_q) begin
            if (tval_q != 32'd0) begin
                tval_d = tval_q - 32'd1;
            end else begin
                fire_s = 1'b1;
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = {tcfg_q[31:TCFG_INITV_LO], 2'b00};
                end else begin
                    en_d = 1'b0;
                end
            end
        end else begin
            tval_d = tval_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tid_q  <= 32'd0;
            tcfg_q <= 32'd0;
            tval_q <= 32'd0;
            en_q   <= 1'b0;
        end else begin
            tid_q  <= tid_d;
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            en_q   <= en_d;
        end
    end

    assign tid_o  = tid_q;
    assign tcfg_o = tcfg_q;
    assign tval_o = tval_q;
    assign fire_o = fire_s;

endmodule

// File: rtl/csr_file.sv
// LoongArch32 CSR file serving the writeback stage. Define CSR_TIMER_EN to
// build in the constant timer (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]).
module csr_file
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        ertn_flush,
    input  logic        ws_ex,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_vaddr,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] csr_rvalue,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    logic [31:0] crmd_q, crmd_d;
    logic [31:0] prmd_q, prmd_d;
    logic [31:0] ecfg_q, ecfg_d;
    logic [31:0] estat_q, estat_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] eentry_q, eentry_d;
    logic [31:0] save_q [0:3];
    logic [31:0] save_d [0:3];
    csr_evt_e    evt_s;
    logic        we_s;
    logic        ti_d;
    logic        unused_s;

    // Read strobe is informational only; read data is always driven.
    assign unused_s = csr_re;

    // Exception beats ertn beats a CSR write; losers are dropped for the cycle.
    always_comb begin
        if (ws_ex) begin
            evt_s = EVT_EX;
        end else if (ertn_flush) begin
            evt_s = EVT_ERTN;
        end else if (csr_we) begin
            evt_s = EVT_WRITE;
        end else begin
            evt_s = EVT_NONE;
        end
    end

    assign we_s = (evt_s == EVT_WRITE);

`ifdef CSR_TIMER_EN
    logic [31:0] tid_s, tcfg_s, tval_s;
    logic        ti_fire_s;
    logic        ticlr_s;

    csr_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .we_i     (we_s),
        .num_i    (csr_num),
        .wmask_i  (csr_wmask),
        .wvalue_i (csr_wvalue),
        .tid_o    (tid_s),
        .tcfg_o   (tcfg_s),
        .tval_o   (tval_s),
        .fire_o   (ti_fire_s)
    );

    // Timer interrupt bit: a fire in the same cycle as a TICLR clear wins.
    always_comb begin
        ticlr_s = we_s && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
        if (ti_fire_s) begin
            ti_d = 1'b1;
        end else if (ticlr_s) begin
            ti_d = 1'b0;
        end else begin
            ti_d = estat_q[ESTAT_IS_TI];
        end
    end
`else
    assign ti_d = 1'b0;
`endif

    // Next-state for the architectural registers.
    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        estat_d  = estat_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        save_d   = save_q;
        case (evt_s)
            EVT_EX: begin
                prmd_d[PRMD_PPLV_LO +: 2]   = crmd_q[CRMD_PLV_LO +: 2];
                prmd_d[PRMD_PIE]            = crmd_q[CRMD_IE];
                crmd_d[CRMD_PLV_LO +: 2]    = 2'b00;
                crmd_d[CRMD_IE]             = 1'b0;
                era_d                       = ws_pc;
                estat_d[ESTAT_ECODE_LO +: 6] = ws_ecode;
                estat_d[ESTAT_ESUB_LO +: 9]  = ws_esubcode;
                if (ws_ecode == ECODE_ADEF) begin
                    badv_d = ws_pc;
                end else if (ws_ecode == ECODE_ALE) begin
                    badv_d = ws_vaddr;
                end else begin
                    badv_d = badv_q;
                end
            end
            EVT_ERTN: begin
                crmd_d[CRMD_PLV_LO +: 2] = prmd_q[PRMD_PPLV_LO +: 2];
                crmd_d[CRMD_IE]          = prmd_q[PRMD_PIE];
            end
            EVT_WRITE: begin
                case (csr_num)
                    CSR_CRMD:   crmd_d   = csr_merge(crmd_q, csr_wmask & CRMD_WMASK, csr_wvalue);
                    CSR_PRMD:   prmd_d   = csr_merge(prmd_q, csr_wmask & PRMD_WMASK, csr_wvalue);
                    CSR_ECFG:   ecfg_d   = csr_merge(ecfg_q, csr_wmask & ECFG_WMASK, csr_wvalue);
                    CSR_ESTAT:  estat_d  = csr_merge(estat_q, csr_wmask & ESTAT_WMASK, csr_wvalue);
                    CSR_ERA:    era_d    = csr_merge(era_q, csr_wmask, csr_wvalue);
                    CSR_BADV:   badv_d   = csr_merge(badv_q, csr_wmask, csr_wvalue);
                    CSR_EENTRY: eentry_d = csr_merge(eentry_q, csr_wmask & EENTRY_WMASK, csr_wvalue);
                    CSR_SAVE0:  save_d[0] = csr_merge(save_q[0], csr_wmask, csr_wvalue);
                    CSR_SAVE1:  save_d[1] = csr_merge(save_q[1], csr_wmask, csr_wvalue);
                    CSR_SAVE2:  save_d[2] = csr_merge(save_q[2], csr_wmask, csr_wvalue);
                    CSR_SAVE3:  save_d[3] = csr_merge(save_q[3], csr_wmask, csr_wvalue);
                    default:    crmd_d   = crmd_q;
                endcase
            end
            default: crmd_d = crmd_q;
        endcase
        // Interrupt lines are re-sampled every cycle regardless of the event.
        estat_d[ESTAT_IS_HW_LO +: 8] = hw_int_in;
        estat_d[ESTAT_IS_RSV]        = 1'b0;
        estat_d[ESTAT_IS_TI]         = ti_d;
        estat_d[ESTAT_IS_IPI]        = ipi_int_in;
    end

    // Architectural register state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_q   <= CRMD_RST;
            prmd_q   <= 32'd0;
            ecfg_q   <= 32'd0;
            estat_q  <= 32'd0;
            era_q    <= 32'd0;
            badv_q   <= 32'd0;
            eentry_q <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= 32'd0;
            end
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            estat_q  <= estat_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

    // Combinational read port over current state.
    always_comb begin
        csr_rvalue = 32'd0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = crmd_q;
            CSR_PRMD:   csr_rvalue = prmd_q;
            CSR_ECFG:   csr_rvalue = ecfg_q;
            CSR_ESTAT:  csr_rvalue = estat_q;
            CSR_ERA:    csr_rvalue = era_q;
            CSR_BADV:   csr_rvalue = badv_q;
            CSR_EENTRY: csr_rvalue = eentry_q;
            CSR_SAVE0:  csr_rvalue = save_q[0];
            CSR_SAVE1:  csr_rvalue = save_q[1];
            CSR_SAVE2:  csr_rvalue = save_q[2];
            CSR_SAVE3:  csr_rvalue = save_q[3];
`ifdef CSR_TIMER_EN
            CSR_TID:    csr_rvalue = tid_s;
            CSR_TCFG:   csr_rvalue = tcfg_s;
            CSR_TVAL:   csr_rvalue = tval_s;
`endif
            default:    csr_rvalue = 32'd0;
        endcase
    end

    assign ex_entry = eentry_q;
    assign ertn_pc  = era_q;
    assign has_int  = crmd_q[CRMD_IE] & (|(estat_q[12:0] & ecfg_q[12:0]));

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table-driven register writes, hand-written
// exception/ertn/interrupt/timer sequences, then random traffic against an array model.
module tb_csr_file;

    localparam int CRMD = 0, PRMD = 1, ECFG = 4, ESTAT = 5, ERA = 6, BADV = 7, EENTRY = 12;
    localparam int SAVE0 = 48, SAVE1 = 49, SAVE3 = 51;
    localparam int TID = 64, TCFG = 65, TVAL = 66, TICLR = 68;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = 14'd0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = 32'd0;
    logic [31:0] csr_wvalue = 32'd0;
    logic        ertn_flush = 1'b0;
    logic        ws_ex = 1'b0;
    logic [31:0] ws_pc = 32'd0;
    logic [31:0] ws_vaddr = 32'd0;
    logic [5:0]  ws_ecode = 6'd0;
    logic [8:0]  ws_esubcode = 9'd0;
    logic [7:0]  hw_int_in = 8'd0;
    logic        ipi_int_in = 1'b0;
    logic [31:0] csr_rvalue;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    csr_file dut (
        .clk         (clk),
        .resetn      (resetn),
        .csr_re      (csr_re),
        .csr_num     (csr_num),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .ertn_flush  (ertn_flush),
        .ws_ex       (ws_ex),
        .ws_pc       (ws_pc),
        .ws_vaddr    (ws_vaddr),
        .ws_ecode    (ws_ecode),
        .ws_esubcode (ws_esubcode),
        .hw_int_in   (hw_int_in),
        .ipi_int_in  (ipi_int_in),
        .csr_rvalue  (csr_rvalue),
        .ex_entry    (ex_entry),
        .ertn_pc     (ertn_pc),
        .has_int     (has_int)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one word per CSR index, writable bits from a table.
    logic [31:0] mreg [0:127];
    logic        m_ten;

    function automatic logic [31:0] wr_bits(input logic [13:0] n);
        case (n)
            14'(CRMD):                  return 32'h0000_01FF;
            14'(PRMD):                  return 32'h0000_0007;
            14'(ECFG):                  return 32'h0000_1BFF;
            14'(ESTAT):                 return 32'h0000_0003;
            14'(ERA), 14'(BADV):        return 32'hFFFF_FFFF;
            14'(EENTRY):                return 32'hFFFF_FFC0;
            14'(48), 14'(49), 14'(50), 14'(51): return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
            14'(TID), 14'(TCFG):        return 32'hFFFF_FFFF;
`endif
            default:                    return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        if (n >= 14'd128 || n == 14'(TICLR)) return 32'd0;
        return mreg[n[6:0]];
    endfunction

    function automatic logic m_hasint();
        return mreg[CRMD][2] & (|(mreg[ESTAT][12:0] & mreg[ECFG][12:0]));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) mreg[i] = 32'd0;
        mreg[CRMD] = 32'h0000_0008;
        m_ten = 1'b0;
    endfunction

    task automatic model_step();
        logic [31:0] nx [0:127];
        logic        fire;
        logic        nten;
        logic        eff;
        logic [31:0] wb;
        if (!resetn) begin
            model_reset();
            return;
        end
        nx   = mreg;
        fire = 1'b0;
        nten = m_ten;
        eff  = csr_we && !ws_ex && !ertn_flush;
        if (eff && csr_num < 14'd128) begin
            wb = csr_wmask & wr_bits(csr_num);
            nx[csr_num[6:0]] = (mreg[csr_num[6:0]] & ~wb) | (csr_wvalue & wb);
        end
`ifdef CSR_TIMER_EN
        if (eff && csr_num == 14'(TCFG)) begin
            nx[TVAL] = {nx[TCFG][31:2], 2'b00};
            nten     = nx[TCFG][0];
        end else if (m_ten) begin
            if (mreg[TVAL] != 32'd0) begin
                nx[TVAL] = mreg[TVAL] - 32'd1;
            end else begin
                fire = 1'b1;
                if (mreg[TCFG][1]) nx[TVAL] = {mreg[TCFG][31:2], 2'b00};
                else nten = 1'b0;
            end
        end
`endif
        nx[ESTAT][9:2] = hw_int_in;
        nx[ESTAT][10]  = 1'b0;
        nx[ESTAT][12]  = ipi_int_in;
        if (fire) nx[ESTAT][11] = 1'b1;
        else if (eff && csr_num == 14'(TICLR) && csr_wmask[0] && csr_wvalue[0]) nx[ESTAT][11] = 1'b0;
        if (ws_ex) begin
            nx[PRMD][2:0]   = mreg[CRMD][2:0];
            nx[CRMD][2:0]   = 3'b000;
            nx[ERA]         = ws_pc;
            nx[ESTAT][21:16] = ws_ecode;
            nx[ESTAT][30:22] = ws_esubcode;
            if (ws_ecode == 6'h08) nx[BADV] = ws_pc;
            else if (ws_ecode == 6'h09) nx[BADV] = ws_vaddr;
        end else if (ertn_flush) begin
            nx[CRMD][2:0] = mreg[PRMD][2:0];
        end
        mreg  = nx;
        m_ten = nten;
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    // One clock: compare all outputs with the model, then advance both.
    task automatic cycle();
        #1;
        chk("rvalue", csr_rvalue, m_read(csr_num));
        chk("ex_entry", ex_entry, mreg[EENTRY]);
        chk("ertn_pc", ertn_pc, mreg[ERA]);
        chk("has_int", {31'd0, has_int}, {31'd0, m_hasint()});
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic peek(input int num, input logic [31:0] msk, input logic [31:0] exp, input string nm);
        csr_we  = 1'b0;
        csr_num = 14'(num);
        #1;
        chk(nm, csr_rvalue & msk, exp);
    endtask

    task automatic wr(input int num, input logic [31:0] msk, input logic [31:0] val);
        csr_we = 1'b1; csr_num = 14'(num); csr_wmask = msk; csr_wvalue = val;
        cycle();
        csr_we = 1'b0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic [31:0] va, input logic [5:0] ec, input logic [8:0] sub);
        ws_ex = 1'b1; ws_pc = pc; ws_vaddr = va; ws_ecode = ec; ws_esubcode = sub;
        cycle();
        ws_ex = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];
    int   pick_tbl [16] = '{0, 1, 4, 5, 6, 7, 12, 48, 49, 50, 51, 64, 65, 66, 68, 2};
    logic [5:0] ec_tbl [6] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};

    initial begin
        tbl[0]  = '{14'(CRMD),   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{14'(CRMD),   32'h0000_00F0, 32'hFFFF_FFFF, 32'h0000_00F0};
        tbl[2]  = '{14'(PRMD),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        tbl[3]  = '{14'(ECFG),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        tbl[4]  = '{14'(ESTAT),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[5]  = '{14'(ERA),    32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        tbl[6]  = '{14'(BADV),   32'hFFFF_0000, 32'hDEAD_BEEF, 32'hDEAD_0000};
        tbl[7]  = '{14'(EENTRY), 32'hFFFF_FFFF, 32'h1C00_8123, 32'h1C00_8100};
        tbl[8]  = '{14'(SAVE3),  32'h0F0F_0F0F, 32'hA5A5_A5A5, 32'h0505_0505};
        tbl[9]  = '{14'h0002,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef CSR_TIMER_EN
        tbl[10] = '{14'(TID),    32'hFFFF_FFFF, 32'hCAFE_F00D, 32'hCAFE_F00D};
`else
        tbl[10] = '{14'(TID),    32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0000_0000};
`endif
        tbl[11] = '{14'(TVAL),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{14'(TICLR),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[13] = '{14'h3FFF,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[14] = '{14'h0130,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        peek(CRMD, 32'hFFFF_FFFF, 32'h0000_0008, "reset_crmd");
        peek(ERA, 32'hFFFF_FFFF, 32'h0000_0000, "reset_era");
        chk("reset_has_int", {31'd0, has_int}, 32'd0);
        chk("reset_ex_entry", ex_entry, 32'd0);

        for (int i = 0; i < 15; i++) begin
            wr(int'(tbl[i].num), tbl[i].mask, tbl[i].val);
            peek(int'(tbl[i].num), 32'hFFFF_FFFF, tbl[i].exp, "table");
        end

        // Masked write; the old value is visible during the write cycle.
        csr_we = 1'b1; csr_num = 14'(SAVE0); csr_wmask = 32'h0000_FF00; csr_wvalue = 32'hFFFF_FFFF;
        #1;
        chk("save0_same_cycle", csr_rvalue, 32'h0000_0000);
        cycle();
        peek(SAVE0, 32'hFFFF_FFFF, 32'h0000_FF00, "save0_next_cycle");

        // Reset wins over a concurrent write and exception.
        csr_we = 1'b1; csr_num = 14'(SAVE0); csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h0000_1234;
        ws_ex = 1'b1; ws_pc = 32'h0000_4444; ws_ecode = 6'h08;
        do_reset();
        csr_we = 1'b0; ws_ex = 1'b0;
        peek(CRMD, 32'hFFFF_FFFF, 32'h0000_0008, "midreset_crmd");
        peek(SAVE0, 32'hFFFF_FFFF, 32'h0000_0000, "midreset_save0");
        peek(ERA, 32'hFFFF_FFFF, 32'h0000_0000, "midreset_era");
        peek(EENTRY, 32'hFFFF_FFFF, 32'h0000_0000, "midreset_eentry");

        // ADEF entry, then ertn.
        wr(CRMD, 32'hFFFF_FFFF, 32'h0000_0007);
        exc(32'h1C00_0100, 32'hBAD0_BAD0, 6'h08, 9'h000);
        peek(PRMD, 32'hFFFF_FFFF, 32'h0000_0007, "ex_prmd");
        peek(CRMD, 32'h0000_0007, 32'h0000_0000, "ex_crmd");
        peek(ERA, 32'hFFFF_FFFF, 32'h1C00_0100, "ex_era");
        peek(BADV, 32'hFFFF_FFFF, 32'h1C00_0100, "ex_badv_adef");
        cycle();
        peek(ESTAT, 32'h003F_0000, 32'h0008_0000, "ex_ecode");
        chk("ex_ertn_pc", ertn_pc, 32'h1C00_0100);
        ertn_flush = 1'b1;
        cycle();
        ertn_flush = 1'b0;
        peek(CRMD, 32'h0000_0007, 32'h0000_0007, "ertn_crmd");

        // ALE takes vaddr; SYS leaves BADV alone.
        exc(32'h1C00_0200, 32'h0000_1233, 6'h09, 9'h000);
        peek(BADV, 32'hFFFF_FFFF, 32'h0000_1233, "ex_badv_ale");
        exc(32'h1C00_0300, 32'h7777_7777, 6'h0B, 9'h1A5);
        peek(BADV, 32'hFFFF_FFFF, 32'h0000_1233, "ex_badv_sys");
        peek(ERA, 32'hFFFF_FFFF, 32'h1C00_0300, "ex_era_sys");
        peek(ESTAT, 32'h7FFF_0000, 32'h694B_0000, "ex_esub");

        // Exception beats ertn and a write in the same cycle.
        wr(CRMD, 32'hFFFF_FFFF, 32'h0000_0007);
        wr(SAVE1, 32'hFFFF_FFFF, 32'h1111_1111);
        ws_ex = 1'b1; ertn_flush = 1'b1; ws_pc = 32'h1C00_0400; ws_ecode = 6'h0C;
        csr_we = 1'b1; csr_num = 14'(SAVE1); csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h2222_2222;
        cycle();
        ws_ex = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
        peek(SAVE1, 32'hFFFF_FFFF, 32'h1111_1111, "prio_save1");
        peek(CRMD, 32'h0000_0007, 32'h0000_0000, "prio_crmd");
        peek(PRMD, 32'h0000_0007, 32'h0000_0007, "prio_prmd");
        // Ertn beats a write.
        ertn_flush = 1'b1;
        csr_we = 1'b1; csr_num = 14'(CRMD); csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h0000_0000;
        cycle();
        ertn_flush = 1'b0; csr_we = 1'b0;
        peek(CRMD, 32'h0000_0007, 32'h0000_0007, "prio_ertn_crmd");

        // Hardware interrupt line 0 -> IS[2].
        wr(ECFG, 32'hFFFF_FFFF, 32'h0000_0004);
        hw_int_in = 8'h01;
        #1;
        chk("int_not_yet", {31'd0, has_int}, 32'd0);
        cycle();
        chk("int_raised", {31'd0, has_int}, 32'd1);
        hw_int_in = 8'h00;
        cycle();
        chk("int_dropped", {31'd0, has_int}, 32'd0);

`ifdef CSR_TIMER_EN
        wr(TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        peek(TVAL, 32'hFFFF_FFFF, 32'h0000_0008, "tval_load");
        for (int k = 1; k <= 8; k++) begin
            cycle();
            peek(TVAL, 32'hFFFF_FFFF, 32'(8 - k), "tval_count");
            peek(ESTAT, 32'h0000_0800, 32'h0000_0000, "ti_early");
        end
        cycle();
        peek(ESTAT, 32'h0000_0800, 32'h0000_0800, "ti_fire");
        peek(TVAL, 32'hFFFF_FFFF, 32'h0000_0008, "tval_reload");
        wr(TICLR, 32'h0000_0001, 32'h0000_0001);
        peek(ESTAT, 32'h0000_0800, 32'h0000_0000, "ticlr");
        wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (12) cycle();
        peek(TVAL, 32'hFFFF_FFFF, 32'h0000_0000, "oneshot_stop");
        peek(ESTAT, 32'h0000_0800, 32'h0000_0800, "oneshot_fire");
        wr(TICLR, 32'h0000_0001, 32'h0000_0001);
        repeat (6) cycle();
        peek(ESTAT, 32'h0000_0800, 32'h0000_0000, "oneshot_no_refire");
        wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0003);
        wr(TICLR, 32'h0000_0001, 32'h0000_0001);
        peek(ESTAT, 32'h0000_0800, 32'h0000_0800, "fire_beats_ticlr");
        wr(TCFG, 32'hFFFF_FFFF, 32'h0000_0000);
`else
        wr(TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        repeat (12) cycle();
        peek(TCFG, 32'hFFFF_FFFF, 32'h0000_0000, "notimer_tcfg");
        peek(TVAL, 32'hFFFF_FFFF, 32'h0000_0000, "notimer_tval");
        peek(ESTAT, 32'h0000_0800, 32'h0000_0000, "notimer_is11");
`endif

        // Random traffic against the model.
        do_reset();
        for (int r = 0; r < 800; r++) begin
            int p;
            resetn     = ($urandom_range(0, 79) != 0);
            csr_we     = ($urandom_range(0, 1) == 1);
            p          = $urandom_range(0, 15);
            csr_num    = (p == 15) ? 14'($urandom) : 14'(pick_tbl[p]);
            csr_wmask  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue = $urandom;
            if (csr_num == 14'(TCFG)) csr_wvalue = csr_wvalue & 32'h0000_003F;
            ws_ex      = ($urandom_range(0, 9) == 0);
            ertn_flush = ($urandom_range(0, 7) == 0);
            ws_pc      = $urandom;
            ws_vaddr   = $urandom;
            p          = $urandom_range(0, 6);
            ws_ecode   = (p == 6) ? 6'($urandom) : ec_tbl[p];
            ws_esubcode = 9'($urandom);
            hw_int_in  = 8'($urandom);
            ipi_int_in = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Control/status register file for the in-order LoongArch32 pipeline; the responder end of the writeback stage's CSR port. It serves combinational CSR reads to writeback and applies CSR writes on the clock edge. It commits exception entry (ws_ex) and exception return (ertn_flush) state changes. It also maintains interrupt status and the constant timer, and exports the exception entry vector, the return PC and the pending-interrupt flag.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- csr_re  in  1  read strobe (informational; read data is always driven)
- csr_num  in  14  CSR index, shared by read and write
- csr_we  in  1  write enable, already gated by writeback valid
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- ertn_flush  in  1  ertn commits this cycle
- ws_ex  in  1  exception commits this cycle
- ws_pc  in  32  PC of the excepting instruction
- ws_vaddr  in  32  faulting data address (ALE)
- ws_ecode  in  6  exception code
- ws_esubcode  in  9  exception subcode
- hw_int_in  in  8  hardware interrupt lines, level
- ipi_int_in  in  1  inter-processor interrupt, level
- csr_rvalue  out  32  read data for csr_num, combinational
- ex_entry  out  32  EENTRY value
- ertn_pc  out  32  ERA value
- has_int  out  1  enabled interrupt pending

## Operation
- Implemented registers and their writable bits:
  - CRMD 0x0: bits [8:0].
  - PRMD 0x1: bits [2:0].
  - ECFG 0x4: LIE, bits [9:0] and [12:11].
  - ESTAT 0x5: only IS[1:0] writable.
  - ERA 0x6: all bits.
  - BADV 0x7: all bits.
  - EENTRY 0xC: bits [31:6].
  - SAVE0–3 0x30–0x33: all bits.
  - TID 0x40: all bits.
  - TCFG 0x41: all bits.
  - TVAL 0x42: read-only.
  - TICLR 0x44: write-1 to bit0; reads 0.
- Unimplemented index: reads 0, writes ignored.
- Write rule: new = (old & ~wmask) | (wvalue & wmask), applied only to writable bits.
- Exception entry (ws_ex = 1):
  - PRMD.PPLV←CRMD.PLV and PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0 and CRMD.IE←0.
  - ERA←ws_pc.
  - ESTAT.Ecode[21:16]←ws_ecode and ESTAT.EsubCode[30:22]←ws_esubcode.
  - BADV←ws_pc when ecode is 0x08 (ADEF); BADV←ws_vaddr when ecode is 0x09 (ALE); otherwise BADV unchanged.
- Exception return (ertn_flush = 1): CRMD.PLV←PRMD.PPLV and CRMD.IE←PRMD.PIE.
- Same-cycle priority: ws_ex over ertn_flush over csr_we. A lower-priority event is dropped entirely for that cycle.
- Interrupt status bits:
  - ESTAT.IS[9:2] is sampled from hw_int_in every cycle.
  - IS[12] is sampled from ipi_int_in every cycle.
  - IS[11] is the timer bit.
  - IS[10] reads 0.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- ex_entry = EENTRY and ertn_pc = ERA, both taken from current register state.

## Timing
- All state updates happen on posedge clk. Reads are combinational from current state, so reading a register in the same cycle it is written returns the old value.
- Reset values:
  - CRMD = 0x0000_0008 (DA = 1).
  - Every other register = 0, including the internal timer enable.
  - Resulting outputs: csr_rvalue follows csr_num over the reset state; ex_entry = 0; ertn_pc = 0; has_int = 0.
- Reset asserted mid-operation overrides every concurrent event.
- Timer (when compiled in), evaluated per cycle:
  - A TCFG write sets TVAL←{InitVal[31:2], 2'b00} and sets timer_en←TCFG.En.
  - Otherwise, if timer_en and TVAL ≠ 0: TVAL decrements by 1.
  - If timer_en and TVAL == 0: IS[11]←1. If Periodic, TVAL reloads {InitVal, 2'b00}; if not, timer_en←0.
- TICLR clear (wmask[0] & wvalue[0]) clears IS[11]. A timer fire in the same cycle wins, so IS[11] stays 1.
- TVAL decrement wraps never; the counter stops at 0 unless reloaded.

## Configuration
- CSR_TIMER_EN defined: TID, TCFG, TVAL and TICLR are implemented as described above.
- CSR_TIMER_EN undefined:
  - Indices 0x40–0x44 read 0 and ignore writes.
  - IS[11] is constant 0.
  - No timer logic is synthesized.

## Structure
- Shared package csr_pkg holds:
  - CSR index constants (CSR_CRMD … CSR_TICLR).
  - Ecode constants (ECODE_INT 0x0, ECODE_ADEF 0x8, ECODE_ALE 0x9, ECODE_SYS 0xB, ECODE_BRK 0xC, ECODE_INE 0xD).
  - CRMD, PRMD, ESTAT and TCFG field bit positions.
- Sub-module csr_timer contains:
  - TCFG, TVAL and TID state.
  - The timer_en flag.
  - The IS[11] set pulse.
- csr_timer is instantiated only under CSR_TIMER_EN.

## Test plan
- Reset, then read CRMD and ERA → 0x8 and 0x0; has_int = 0.
- Write CSR_SAVE0 with wvalue 0xFFFF_FFFF and wmask 0x0000_FF00 → the read returns 0x0000_FF00 on the next cycle; a read in the write cycle returns 0.
- With CRMD = 0x7 (PLV 3, IE 1), raise ws_ex with ws_pc 0x1C00_0100 and ecode 0x08 → PRMD = 0x7, CRMD[2:0] = 0, ERA = BADV = 0x1C00_0100, ESTAT[21:16] = 0x08. Then ertn_flush → CRMD[2:0] = 0x7.
- Raise ws_ex, ertn_flush and a csr_we to SAVE1 in the same cycle → only the exception takes effect; SAVE1 unchanged.
- Set ECFG.LIE[2] = 1, CRMD.IE = 1, hw_int_in = 0x01 → has_int = 1 one cycle later; drop hw_int_in → has_int = 0.
- (CSR_TIMER_EN) Write TCFG = 0x0000_000B (InitVal 2, periodic, enabled):
  - TVAL = 8, counts down to 0; IS[11] sets 9 cycles after the write and TVAL reloads to 8.
  - TICLR write of 1 clears IS[11].
  - With Periodic = 0 the timer stops at 0.
